// File: rtl/lpc_ctrl_pkg.sv
// Shared constants, register map and solve-FSM state type for the LPC frame controller.
package lpc_ctrl_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned LEN_W  = 11;
    localparam int unsigned IDX_W  = 11;

    localparam logic [15:0] ADDR_FRAME_LEN = 16'h0000;
    localparam logic [15:0] ADDR_CTRL      = 16'h0001;
    localparam logic [15:0] ADDR_STATUS    = 16'h0002;
    localparam logic [15:0] ADDR_FRAME_CNT = 16'h0003;

    localparam int unsigned CTRL_RUN     = 0;
    localparam int unsigned CTRL_IRQ_EN  = 1;
    localparam int unsigned CTRL_CLEAR   = 2;
    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_OVERRUN = 1;
    localparam int unsigned STAT_DONE    = 2;

    localparam int unsigned FRAME_LEN_DEF = 240;
    localparam int unsigned FRAME_LEN_LO  = 16;
    localparam int unsigned FRAME_LEN_HI  = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        LATCH = 2'd3
    } solve_state_t;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [15:0] wd,
                                                   input int unsigned lo,
                                                   input int unsigned hi);
        if (32'(wd) < lo)      return LEN_W'(lo);
        else if (32'(wd) > hi) return LEN_W'(hi);
        else                   return LEN_W'(wd);
    endfunction

endpackage

// File: rtl/lpc_tick_sync.sv
// Synchronizes the sample clock into the system domain and emits a one-cycle tick per rising edge.
module lpc_tick_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_tick_c
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= (r_sync << 1) | SYNC_STAGES'(i_d);
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_tick_c = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/lpc_frame_ctrl.sv
// LPC frame sequencer: sample strobes, frame counting, solver handshake and host registers.
// Optional LPC_CTRL_IRQ_EN adds the irq output and CTRL.irq_en storage.
module lpc_frame_ctrl
    import lpc_ctrl_pkg::*;
#(
    parameter int unsigned FRAME_LEN_RST = FRAME_LEN_DEF,
    parameter int unsigned FRAME_LEN_MIN = FRAME_LEN_LO,
    parameter int unsigned FRAME_LEN_MAX = FRAME_LEN_HI,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_clk,
    input  logic        v,
    input  logic [15:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        samp_en,
    output logic        frame_first,
    output logic        solve_start,
    input  logic        solve_done,
    output logic        coef_latch,
    output logic [15:0] frame_cnt,
    output logic        irq
);

    logic               w_tick;
    logic               w_accept;
    logic               w_last;
    logic               w_frame_end;
    logic [IDX_W-1:0]   r_idx;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_len_act;
    logic               r_frame_end;
    logic               r_run;
    logic               w_irq_en;
    logic               r_overrun;
    logic               r_done;
    logic [15:0]        r_frame_cnt;
    logic [15:0]        r_readdata;
    logic [15:0]        w_rdata;
    logic               r_samp_en;
    logic               r_frame_first;
    logic               r_solve_start;
    logic               r_coef_latch;
    solve_state_t       r_state;
    solve_state_t       w_state_nxt;
    logic               w_enter_latch;
    logic               w_drop;
    logic               w_wr_len;
    logic               w_wr_ctrl;
    logic               w_wr_stat;
    logic               w_clear;

    lpc_tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
        .i_clk    (clk),
        .i_rst_n  (rst),
        .i_d      (d_clk),
        .o_tick_c (w_tick)
    );

    assign w_accept    = w_tick & r_run & v;
    assign w_last      = (r_idx == IDX_W'(r_len_act - LEN_W'(1)));
    assign w_frame_end = w_accept & w_last;

    // Sample index; active length reloads at each frame boundary and while stopped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx         <= '0;
            r_len_act     <= LEN_W'(FRAME_LEN_RST);
            r_samp_en     <= 1'b0;
            r_frame_first <= 1'b0;
            r_frame_end   <= 1'b0;
        end else begin
            if (!r_run) begin
                r_idx     <= '0;
                r_len_act <= r_len;
            end else if (w_accept) begin
                r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
                if (w_last) r_len_act <= r_len;
            end
            r_samp_en     <= w_accept;
            r_frame_first <= w_accept & (r_idx == '0);
            r_frame_end   <= w_frame_end;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (r_frame_end) w_state_nxt = START;
            START:   w_state_nxt = WAIT;
            WAIT:    if (solve_done) w_state_nxt = LATCH;
            LATCH:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_enter_latch = (r_state == WAIT) & solve_done;
    assign w_drop        = r_frame_end & (r_state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_solve_start <= 1'b0;
            r_coef_latch  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_solve_start <= (w_state_nxt == START);
            r_coef_latch  <= (w_state_nxt == LATCH);
        end
    end

    assign w_wr_len  = write & (address == ADDR_FRAME_LEN);
    assign w_wr_ctrl = write & (address == ADDR_CTRL);
    assign w_wr_stat = write & (address == ADDR_STATUS);
    assign w_clear   = w_wr_ctrl & writedata[CTRL_CLEAR];

    // Clear beats W1C, which beats a same-cycle set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len       <= LEN_W'(FRAME_LEN_RST);
            r_run       <= 1'b0;
            r_overrun   <= 1'b0;
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_wr_len)  r_len <= clamp_len(writedata, FRAME_LEN_MIN, FRAME_LEN_MAX);
            if (w_wr_ctrl) r_run <= writedata[CTRL_RUN];
            if (w_clear)            r_frame_cnt <= '0;
            else if (w_enter_latch) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_clear)                                r_done <= 1'b0;
            else if (w_wr_stat && writedata[STAT_DONE]) r_done <= 1'b0;
            else if (w_enter_latch)                     r_done <= 1'b1;
            if (w_clear)                                   r_overrun <= 1'b0;
            else if (w_wr_stat && writedata[STAT_OVERRUN]) r_overrun <= 1'b0;
            else if (w_drop)                               r_overrun <= 1'b1;
        end
    end

`ifdef LPC_CTRL_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_irq_en <= writedata[CTRL_IRQ_EN];
            r_irq <= r_done & r_irq_en;
        end
    end

    assign w_irq_en = r_irq_en;
    assign irq      = r_irq;
`else
    assign w_irq_en = 1'b0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        unique case (address)
            ADDR_FRAME_LEN: w_rdata = 16'(r_len);
            ADDR_CTRL:      w_rdata = {14'd0, w_irq_en, r_run};
            ADDR_STATUS:    w_rdata = {13'd0, r_done, r_overrun, (r_state != IDLE)};
            ADDR_FRAME_CNT: w_rdata = r_frame_cnt;
            default:        w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      r_readdata <= '0;
        else if (read) r_readdata <= w_rdata;
    end

    assign readdata    = r_readdata;
    assign samp_en     = r_samp_en;
    assign frame_first = r_frame_first;
    assign solve_start = r_solve_start;
    assign coef_latch  = r_coef_latch;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_lpc_frame_ctrl.sv
// Directed self-checking bench for lpc_frame_ctrl.
module tb_lpc_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        d_clk = 1'b0;
    logic        v = 1'b0;
    logic [15:0] address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        samp_en;
    logic        frame_first;
    logic        solve_start;
    logic        solve_done = 1'b0;
    logic        coef_latch;
    logic [15:0] frame_cnt;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int n_samp = 0, n_first = 0, n_start = 0, n_latch = 0;
    int last_samp_cyc = 0, start_cyc = 0, latch_cyc = 0, done_cyc = 0, first_idx = 0;

`ifdef LPC_CTRL_IRQ_EN
    localparam logic IRQ_EXP  = 1'b1;
    localparam int   CTRL_EXP = 3;
`else
    localparam logic IRQ_EXP  = 1'b0;
    localparam int   CTRL_EXP = 1;
`endif

    lpc_frame_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .d_clk       (d_clk),
        .v           (v),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .readdata    (readdata),
        .samp_en     (samp_en),
        .frame_first (frame_first),
        .solve_start (solve_start),
        .solve_done  (solve_done),
        .coef_latch  (coef_latch),
        .frame_cnt   (frame_cnt),
        .irq         (irq)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (samp_en) begin
            n_samp = n_samp + 1;
            last_samp_cyc = cyc;
            if (frame_first) first_idx = n_samp;
        end
        if (frame_first) n_first = n_first + 1;
        if (solve_start) begin n_start = n_start + 1; start_cyc = cyc; end
        if (coef_latch)  begin n_latch = n_latch + 1; latch_cyc = cyc; end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic host_wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic host_rd(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic tick(input logic val, output int lat);
        @(negedge clk);
        d_clk = 1'b1; v = val; lat = 0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (samp_en && lat == 0) lat = k;
        end
        @(negedge clk);
        d_clk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic ticks(input int n, input logic val);
        int lat;
        for (int i = 0; i < n; i++) tick(val, lat);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        solve_done = 1'b1; done_cyc = cyc;
        @(negedge clk);
        solve_done = 1'b0;
    endtask

    initial begin
        logic [15:0] rd;
        int lat, s0, st0, f0;

        repeat (3) @(negedge clk);
        check("rst_readdata", 32'(readdata), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_strobes", {29'd0, samp_en, solve_start, coef_latch}, 0);
        rst = 1'b1;
        host_rd(16'h0, rd); check("rst_frame_len", 32'(rd), 240);
        host_rd(16'h2, rd); check("rst_status", 32'(rd), 0);

        // First full 240-sample frame
        host_wr(16'h0, 16'd240);
        host_wr(16'h1, 16'h1);
        tick(1'b1, lat);
        check("samp_latency", 32'(lat), 3);
        check("first_cnt", 32'(n_first), 1);
        check("first_idx", 32'(first_idx), 1);
        ticks(239, 1'b1);
        repeat (3) @(negedge clk);
        check("samp_cnt", 32'(n_samp), 240);
        check("start_cnt", 32'(n_start), 1);
        check("start_delay", 32'(start_cyc - last_samp_cyc), 1);
        host_rd(16'h2, rd); check("status_busy", 32'(rd), 1);
        pulse_done();
        repeat (2) @(negedge clk);
        check("latch_cnt", 32'(n_latch), 1);
        check("latch_delay", 32'(latch_cyc - done_cyc), 1);
        host_rd(16'h3, rd); check("frame_cnt_rd", 32'(rd), 1);
        check("frame_cnt_port", 32'(frame_cnt), 1);
        host_rd(16'h2, rd); check("status_done", 32'(rd), 4);
        check("irq_off", 32'(irq), 0);

        // Interrupt enable and W1C done
        host_wr(16'h1, 16'h3);
        repeat (2) @(negedge clk);
        check("irq_on", 32'(irq), 32'(IRQ_EXP));
        host_rd(16'h1, rd); check("ctrl_rd", 32'(rd), CTRL_EXP);
        host_wr(16'h2, 16'h4);
        @(negedge clk);
        check("irq_w1c", 32'(irq), 0);

        // Clamping, read/write collision, unmapped address
        host_wr(16'h0, 16'd5);    host_rd(16'h0, rd); check("clamp_min", 32'(rd), 16);
        host_wr(16'h0, 16'd2000); host_rd(16'h0, rd); check("clamp_max", 32'(rd), 1024);
        @(negedge clk);
        address = 16'h0; writedata = 16'd20; read = 1'b1; write = 1'b1;
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        check("rw_prewrite", 32'(readdata), 1024);
        host_rd(16'h0, rd); check("rw_postwrite", 32'(rd), 20);
        host_wr(16'h5, 16'hFFFF); host_rd(16'h5, rd); check("unmapped", 32'(rd), 0);

        // 16-sample frames with invalid ticks interleaved
        host_wr(16'h0, 16'd16);
        host_wr(16'h1, 16'h0);
        host_wr(16'h1, 16'h1);
        s0 = n_samp; st0 = n_start;
        ticks(5, 1'b1);
        ticks(10, 1'b0);
        check("invalid_no_samp", 32'(n_samp - s0), 5);
        ticks(10, 1'b1);
        repeat (2) @(negedge clk);
        check("no_early_end", 32'(n_start - st0), 0);
        ticks(1, 1'b1);
        repeat (2) @(negedge clk);
        check("end_after_len", 32'(n_start - st0), 1);

        // Second frame while still waiting: dropped, overrun
        ticks(16, 1'b1);
        repeat (2) @(negedge clk);
        check("overrun_drop", 32'(n_start - st0), 1);
        host_rd(16'h2, rd); check("status_overrun", 32'(rd), 3);
        host_wr(16'h2, 16'h2);
        host_rd(16'h2, rd); check("overrun_w1c", 32'(rd), 1);
        pulse_done();
        repeat (2) @(negedge clk);
        host_rd(16'h2, rd); check("status_done2", 32'(rd), 4);
        check("frame_cnt2", 32'(frame_cnt), 2);

        // CTRL.clear
        host_wr(16'h1, 16'h5);
        check("clear_cnt", 32'(frame_cnt), 0);
        host_rd(16'h2, rd); check("clear_status", 32'(rd), 0);
        host_rd(16'h1, rd); check("clear_selfclr", 32'(rd), 1);

        // Reset mid-operation
        ticks(16, 1'b1);
        pulse_done();
        ticks(100, 1'b1);
        host_rd(16'h3, rd); check("pre_rst_cnt", 32'(rd), 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_readdata", 32'(readdata), 0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 0);
        check("mid_rst_outs", {28'd0, samp_en, solve_start, coef_latch, irq}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        host_rd(16'h0, rd); check("post_rst_len", 32'(rd), 240);
        host_rd(16'h1, rd); check("post_rst_ctrl", 32'(rd), 0);
        host_rd(16'h2, rd); check("post_rst_status", 32'(rd), 0);
        host_wr(16'h1, 16'h1);
        f0 = n_first;
        tick(1'b1, lat);
        check("restart_first", 32'(n_first - f0), 1);
        check("restart_idx0", 32'(first_idx), 32'(n_samp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
